mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single data RAM between the CPU memory stage (port 0) and a second bus master such as a loader or DMA engine (port 1). It sits between the requesters and the RAM/MMU data port. Each requester gets a req/ack handshake. The arbiter serialises accesses, drives the RAM for exactly one issue cycle per transaction, waits the RAM read latency, and returns read data in a per-port register.

## Interface
- ADDR_WIDTH, 32, address width of both ports and the RAM.
- DATA_WIDTH, 32, data width.
- LATENCY, 1, RAM read latency in cycles; legal range 1..15.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held until ack0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ADDR_WIDTH  port 0 address.
- wdata0  in  DATA_WIDTH  port 0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DATA_WIDTH  port 0 read data register.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid LATENCY cycles after the issue edge.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  port that owns the current or most recent transaction.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - With no req asserted, stay in IDLE.
  - With any req asserted, pick a winner and latch its we, addr and wdata into mem_we, mem_addr and mem_wdata.
  - Set grant_id to the winner and go to ISSUE.
- **ISSUE**
  - mem_en=1 for exactly this one cycle; mem_we follows the latched we.
  - Load the wait counter with LATENCY-1.
  - Go to WAIT if LATENCY>1, otherwise go to RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to RESP when the counter reaches 0.
- **Read capture**
  - mem_rdata is sampled on the edge that enters RESP, i.e. at the edge LATENCY cycles after the issue edge.
  - On reads, the sample goes into rdata[grant_id].
  - On writes, rdata is unchanged.
- **RESP**
  - ack[grant_id]=1 for this one cycle; the other ack stays 0.
  - Always go to IDLE next.
- mem_en and mem_we are 0 in every state except ISSUE. mem_addr and mem_wdata hold their last value.
- **Ties:** when both req are asserted in IDLE, the port not granted last wins (see Configuration).
- **Requester rules**
  - A requester keeps req, we, addr and wdata stable until it sees ack.
  - It may drop req, or re-assert it with a new request, on the edge after ack.
- **Protocol violation:** if req drops after the arbiter has latched the request, the transaction still completes and ack still pulses. The arbiter never aborts a transaction.
- **Requests arriving while busy** stay pending; they are evaluated at the next IDLE.

## Timing
- **Reset values:** ack0=ack1=0, rdata0=rdata1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, grant_id=0. FSM=IDLE, counter=0, last-grant=1.
- **Transaction timeline:** req sampled in IDLE at cycle t gives:
  - ISSUE at t+1;
  - WAIT at t+2..t+LATENCY;
  - RESP, with ack and rdata valid, at t+LATENCY+1;
  - IDLE at t+LATENCY+2.
- **Throughput:** back-to-back transactions occupy LATENCY+2 cycles each.
- **Reset asserted mid-transaction:**
  - All outputs return to their reset values immediately, with no ack.
  - A write already issued in ISSUE stands.
  - Any pending request is re-arbitrated after reset releases.
- **Reset release:** the first arbitration happens on the first rising edge with reset high.

## Configuration
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- **Defined:** round-robin arbitration.
  - Last-grant updates on every grant.
  - On a tie, the port other than last-grant wins, so port 0 wins the first tie after reset.
  - Neither port can be starved for more than one transaction.
- **Undefined:** fixed priority.
  - Port 0 always wins ties.
  - The last-grant register is not implemented.
  - Port 1 is served only when req0 is low in IDLE.

## Test plan
- **Single read, LATENCY=1:** port 0 read at addr 3, RAM word 3 = 0x1234.
  - mem_en is high for exactly one cycle at t+1.
  - ack0 pulses at t+2 with rdata0=0x1234.
  - busy is low at t+3.
- **Write then read, LATENCY=3:** port 1 writes 0xCAFE to addr 7, then reads addr 7.
  - Each ack1 arrives 4 cycles after the IDLE sample.
  - Read returns rdata1=0xCAFE; rdata1 is unchanged by the write.
- **Both ports hold req continuously, round-robin build:** grants go 0,1,0,1. Fixed-priority build: grants go 0,0,0,0 and ack1 never pulses.
- **Reset asserted during WAIT with LATENCY=3:**
  - All outputs go to 0 at once and no ack is seen.
  - After reset releases, the held req0 is re-issued and acked.
- **Requester drops req0 in the WAIT cycle:** ack0 still pulses in RESP and the FSM returns to IDLE.
- **Port 1 read while port 0 is mid-transaction:** the port 1 request waits, is granted in the next IDLE, and ack1 arrives LATENCY+1 cycles after that IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter that serialises CPU (port 0) and DMA (port 1) accesses to one data RAM.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.

module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  grant_q, grant_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  win;
  logic                  capture;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    if (req0 && req1) begin
      win = ~last_q;
    end else begin
      win = req1;
    end
  end
`else
  always_comb begin
    win = ~req0;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    capture = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_d = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_d  = win;
`endif
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = CntLoad;
        if (LATENCY > 1) begin
          state_d = StWait;
        end else begin
          state_d = StResp;
          capture = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          capture = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Read data is sampled on the edge that enters RESP; writes leave rdata untouched.
  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (capture && !we_q) begin
      if (grant_q) begin
        rdata1_d = mem_rdata;
      end else begin
        rdata0_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      grant_q  <= grant_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  assign mem_en    = (state_q == StIssue);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ack0      = (state_q == StResp) & ~grant_q;
  assign ack1      = (state_q == StResp) & grant_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = (state_q != StIdle);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LATENCY 1 and 3) with a latency-accurate RAM model,
// directed scenarios and a randomized run against a cycle-arithmetic reference model.

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          ram_load;
  logic          req0 [2];
  logic          we0 [2];
  logic [AW-1:0] addr0 [2];
  logic [DW-1:0] wdata0 [2];
  logic          ack0 [2];
  logic [DW-1:0] rdata0 [2];
  logic          req1 [2];
  logic          we1 [2];
  logic [AW-1:0] addr1 [2];
  logic [DW-1:0] wdata1 [2];
  logic          ack1 [2];
  logic [DW-1:0] rdata1 [2];
  logic          mem_en [2];
  logic          mem_we [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy [2];
  logic          grant_id [2];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_word(input int k, input int i);
    if (i == 3) return 32'h0000_1234;
    return 32'hA500_0000 | (32'(k) << 16) | 32'(i);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LATENCY    ((gi == 0) ? 1 : 3)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .req0      (req0[gi]),
      .we0       (we0[gi]),
      .addr0     (addr0[gi]),
      .wdata0    (wdata0[gi]),
      .ack0      (ack0[gi]),
      .rdata0    (rdata0[gi]),
      .req1      (req1[gi]),
      .we1       (we1[gi]),
      .addr1     (addr1[gi]),
      .wdata1    (wdata1[gi]),
      .ack1      (ack1[gi]),
      .rdata1    (rdata1[gi]),
      .mem_en    (mem_en[gi]),
      .mem_we    (mem_we[gi]),
      .mem_addr  (mem_addr[gi]),
      .mem_wdata (mem_wdata[gi]),
      .mem_rdata (mem_rdata[gi]),
      .busy      (busy[gi]),
      .grant_id  (grant_id[gi])
    );
  end

  // RAM: writes land on the edge ending the issue cycle; read data is only valid in the
  // cycle before the edge LATENCY cycles after the issue edge, garbage otherwise.
  logic [31:0] ram [2][16];
  int          age [2] = '{0, 0};

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_load) begin
        for (int i = 0; i < 16; i++) ram[k][i] <= init_word(k, i);
      end else if (mem_en[k] && mem_we[k]) begin
        ram[k][mem_addr[k][3:0]] <= mem_wdata[k];
      end
      age[k] <= mem_en[k] ? 1 : ((age[k] < 100) ? age[k] + 1 : age[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      if ((lat_of(k) == 1) ? mem_en[k] : (!mem_en[k] && age[k] == lat_of(k) - 1)) begin
        mem_rdata[k] = ram[k][mem_addr[k][3:0]];
      end else begin
        mem_rdata[k] = ~ram[k][mem_addr[k][3:0]];
      end
    end
  end

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs(input int k);
    req0[k] = 1'b0; we0[k] = 1'b0; addr0[k] = '0; wdata0[k] = '0;
    req1[k] = 1'b0; we1[k] = 1'b0; addr1[k] = '0; wdata1[k] = '0;
  endtask

  function automatic logic [5:0] ctl(input int k);
    return {ack0[k], ack1[k], mem_en[k], mem_we[k], busy[k], grant_id[k]};
  endfunction

  // Steps until the given port's ack is seen; n = cycles stepped, or -1 if the bound expired.
  task automatic wait_ack(input int k, input int p, input int max, output int n);
    bit seen = 1'b0;
    n = -1;
    for (int i = 1; i <= max && !seen; i++) begin
      step();
      if ((p == 0) ? ack0[k] : ack1[k]) begin
        n = i;
        seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ctl(k) !== 6'b0) begin
        errors++; $display("FAIL reset_ctl k=%0d got %b exp 000000", k, ctl(k));
      end
      checks++;
      if (rdata0[k] !== 32'h0 || rdata1[k] !== 32'h0) begin
        errors++; $display("FAIL reset_rdata k=%0d got %h/%h exp 0/0", k, rdata0[k], rdata1[k]);
      end
      checks++;
      if (mem_addr[k] !== 32'h0 || mem_wdata[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_mem k=%0d got %h/%h exp 0/0", k, mem_addr[k], mem_wdata[k]);
      end
    end
  endtask

  task automatic test_single_read();
    int k = 0;
    req0[k] = 1'b1; we0[k] = 1'b0; addr0[k] = 32'd3;
    step();
    checks++;
    if (ctl(k) !== 6'b001010) begin
      errors++; $display("FAIL single_read_issue got %b exp 001010", ctl(k));
    end
    step();
    checks++;
    if (ctl(k) !== 6'b100010 || rdata0[k] !== 32'h1234) begin
      errors++; $display("FAIL single_read_resp got %b/%h exp 100010/1234", ctl(k), rdata0[k]);
    end
    req0[k] = 1'b0;
    step();
    checks++;
    if (busy[k] !== 1'b0 || ack0[k] !== 1'b0) begin
      errors++; $display("FAIL single_read_idle got busy=%b ack0=%b exp 0 0", busy[k], ack0[k]);
    end
  endtask

  task automatic test_write_read();
    int k = 1;
    int n;
    req1[k] = 1'b1; we1[k] = 1'b1; addr1[k] = 32'd7; wdata1[k] = 32'hCAFE;
    step();
    checks++;
    if ({mem_en[k], mem_we[k], grant_id[k]} !== 3'b111 || mem_addr[k] !== 32'd7 ||
        mem_wdata[k] !== 32'hCAFE) begin
      errors++;
      $display("FAIL write_issue got %b%b%b %h %h exp 111 7 cafe", mem_en[k], mem_we[k],
               grant_id[k], mem_addr[k], mem_wdata[k]);
    end
    wait_ack(k, 1, 8, n);
    checks++;
    if (n !== lat_of(k)) begin
      errors++; $display("FAIL write_ack_latency got %0d exp %0d", n, lat_of(k));
    end
    checks++;
    if (rdata1[k] !== 32'h0) begin
      errors++; $display("FAIL write_rdata_unchanged got %h exp 0", rdata1[k]);
    end
    we1[k] = 1'b0; wdata1[k] = '0;
    wait_ack(k, 1, 10, n);
    checks++;
    if (n !== lat_of(k) + 2) begin
      errors++; $display("FAIL read_ack_latency got %0d exp %0d", n, lat_of(k) + 2);
    end
    checks++;
    if (rdata1[k] !== 32'hCAFE) begin
      errors++; $display("FAIL read_after_write got %h exp cafe", rdata1[k]);
    end
    req1[k] = 1'b0;
    step();
  endtask

  task automatic test_contention();
    int k = 1;
    int q[$];
    int exp_g;
    int bound = 4 * (lat_of(k) + 2) + 6;
    reset = 1'b0;
    step();
    req0[k] = 1'b1; we0[k] = 1'b0; addr0[k] = 32'd1;
    req1[k] = 1'b1; we1[k] = 1'b0; addr1[k] = 32'd2;
    reset = 1'b1;
    for (int i = 0; i < bound && q.size() < 4; i++) begin
      step();
      if (ack0[k]) q.push_back(0);
      if (ack1[k]) q.push_back(1);
      if (q.size() >= 4) begin
        req0[k] = 1'b0; req1[k] = 1'b0;
      end
    end
    idle_inputs(k);
    checks++;
    if (q.size() !== 4) begin
      errors++; $display("FAIL contention_count got %0d exp 4", q.size());
    end
    for (int i = 0; i < q.size() && i < 4; i++) begin
      exp_g = RoundRobin ? (i % 2) : 0;
      checks++;
      if (q[i] !== exp_g) begin
        errors++; $display("FAIL contention_grant%0d got %0d exp %0d", i, q[i], exp_g);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    int k = 1;
    int n;
    int acks = 0;
    req0[k] = 1'b1; we0[k] = 1'b0; addr0[k] = 32'd5;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (ctl(k) !== 6'b0 || rdata0[k] !== 32'h0 || rdata1[k] !== 32'h0 ||
        mem_addr[k] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %b %h %h %h exp 000000 0 0 0", ctl(k), rdata0[k],
               rdata1[k], mem_addr[k]);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack0[k] || ack1[k]) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL reset_mid_no_ack got %0d exp 0", acks);
    end
    reset = 1'b1;
    wait_ack(k, 0, lat_of(k) + 4, n);
    checks++;
    if (n !== lat_of(k) + 1 || rdata0[k] !== init_word(k, 5)) begin
      errors++;
      $display("FAIL reset_mid_reissue got %0d/%h exp %0d/%h", n, rdata0[k], lat_of(k) + 1,
               init_word(k, 5));
    end
    req0[k] = 1'b0;
    step();
  endtask

  task automatic test_drop_req();
    int k = 1;
    int n;
    int busy_seen = 0;
    req0[k] = 1'b1; we0[k] = 1'b0; addr0[k] = 32'd9;
    step();
    step();
    req0[k] = 1'b0;
    wait_ack(k, 0, 6, n);
    checks++;
    if (n !== lat_of(k) - 1 || rdata0[k] !== init_word(k, 9)) begin
      errors++;
      $display("FAIL drop_req_ack got %0d/%h exp %0d/%h", n, rdata0[k], lat_of(k) - 1,
               init_word(k, 9));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy[k]) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin
      errors++; $display("FAIL drop_req_idle got %0d busy cycles exp 0", busy_seen);
    end
  endtask

  task automatic test_pending();
    int k = 0;
    int n;
    req0[k] = 1'b1; we0[k] = 1'b0; addr0[k] = 32'd2;
    step();
    req1[k] = 1'b1; we1[k] = 1'b0; addr1[k] = 32'd4;
    wait_ack(k, 0, 4, n);
    req0[k] = 1'b0;
    checks++;
    if (n !== lat_of(k) || rdata0[k] !== init_word(k, 2)) begin
      errors++;
      $display("FAIL pending_ack0 got %0d/%h exp %0d/%h", n, rdata0[k], lat_of(k), init_word(k, 2));
    end
    wait_ack(k, 1, 8, n);
    req1[k] = 1'b0;
    checks++;
    if (n !== lat_of(k) + 2 || rdata1[k] !== init_word(k, 4)) begin
      errors++;
      $display("FAIL pending_ack1 got %0d/%h exp %0d/%h", n, rdata1[k], lat_of(k) + 2,
               init_word(k, 4));
    end
    step();
  endtask

  // Reference: a grant in an idle cycle c issues at c+1, acks at c+L+1, frees the RAM at c+L+2.
  task automatic test_random(input int k, input int ncyc);
    int          lat = lat_of(k);
    logic [31:0] mram [16];
    bit          act [2];
    bit          pwe [2];
    logic [31:0] pad [2];
    logic [31:0] pwd [2];
    logic [31:0] erd [2];
    int          next_idle = 0, ack_at = -1, iss_at = -1;
    int          last = 1, gid = 0, win;
    bit          twe = 1'b0;
    logic [31:0] taddr = '0, twd = '0, resp = '0;
    logic [5:0]  ectl;
    for (int i = 0; i < 16; i++) mram[i] = init_word(k, i);
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; pwe[p] = 1'b0; pad[p] = '0; pwd[p] = '0; erd[p] = '0;
    end
    idle_inputs(k);
    reset = 1'b0; ram_load = 1'b1;
    step();
    ram_load = 1'b0; reset = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (c == ack_at && !twe) erd[gid] = resp;
      ectl = {c == ack_at && gid == 0, c == ack_at && gid == 1, c == iss_at,
              c == iss_at && twe, c < next_idle, gid == 1};
      checks++;
      if (ctl(k) !== ectl) begin
        errors++; $display("FAIL rand_ctl k=%0d c=%0d got %b exp %b", k, c, ctl(k), ectl);
      end
      checks++;
      if (rdata0[k] !== erd[0] || rdata1[k] !== erd[1]) begin
        errors++;
        $display("FAIL rand_rdata k=%0d c=%0d got %h/%h exp %h/%h", k, c, rdata0[k], rdata1[k],
                 erd[0], erd[1]);
      end
      if (c == iss_at) begin
        checks++;
        if (mem_addr[k] !== taddr || (twe && mem_wdata[k] !== twd)) begin
          errors++;
          $display("FAIL rand_mem k=%0d c=%0d got %h/%h exp %h/%h", k, c, mem_addr[k],
                   mem_wdata[k], taddr, twd);
        end
      end
      if (c == ack_at) act[gid] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 2) == 0) begin
          act[p] = 1'b1; pwe[p] = 1'($urandom_range(0, 1)); pad[p] = $urandom; pwd[p] = $urandom;
        end
      end
      req0[k] = act[0]; we0[k] = pwe[0]; addr0[k] = pad[0]; wdata0[k] = pwd[0];
      req1[k] = act[1]; we1[k] = pwe[1]; addr1[k] = pad[1]; wdata1[k] = pwd[1];
      if (c >= next_idle && (act[0] || act[1])) begin
        if (act[0] && act[1]) win = RoundRobin ? 1 - last : 0;
        else win = act[1] ? 1 : 0;
        last = win; gid = win;
        twe = pwe[win]; taddr = pad[win]; twd = pwd[win];
        if (twe) mram[taddr[3:0]] = twd;
        else resp = mram[taddr[3:0]];
        iss_at = c + 1; ack_at = c + lat + 1; next_idle = c + lat + 2;
      end
      step();
    end
    idle_inputs(k);
    for (int i = 0; i < lat + 3; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    ram_load = 1'b1;
    idle_inputs(0);
    idle_inputs(1);
    #2 reset = 1'b0;
    #1 test_reset();
    step();
    ram_load = 1'b0;
    step();
    reset = 1'b1;
    test_single_read();
    test_write_read();
    test_contention();
    test_reset_mid();
    test_drop_req();
    test_pending();
    test_random(0, 300);
    test_random(1, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
